jtcontra_irq_ctrl: RTL and testbench
====================================

Name: jtcontra_irq_ctrl

Overview:
- Parametrised interrupt controller for the main 6809 CPU; replaces the fixed pair of edge flip-flops (IRQ, NMI) with CH programmable channels.
- Each channel has:
  - a source, configurable as falling-edge latched or level-sensitive;
  - a mask bit;
  - a pending bit and a sticky overflow bit.
- Channels are merged into one active-low interrupt line plus a priority vector. CPU-side registers live on a small 8-bit bus, decoded by the game's main decoder.

Parameters:
- CH, 4, number of channels; legal range 1..8.
- MASK0, 8'hFF, reset value of the mask register (1 = channel enabled); bits above CH-1 ignored.
- MODE0, 8'hFF, reset value of the mode register (1 = edge, 0 = level); bits above CH-1 ignored.

Ports:
- clk  in  1  system clock, 24 MHz.
- rstn  in  1  asynchronous active-low reset.
- dip_pause  in  1  1 = running, 0 = paused; new triggers are blocked while low.
- src_n  in  CH  active-low interrupt sources; asynchronous to the CPU, synchronous to clk.
- irq_ack  in  1  single-cycle pulse from the CPU core when it acknowledges the interrupt.
- wr  in  1  register write strobe, one clk cycle.
- addr  in  2  register select.
- din  in  8  write data.
- dout  out  8  read data, combinational from addr.
- irq_n  out  1  registered active-low interrupt request to the CPU.
- vec  out  3  index of the highest-priority unmasked pending channel (0 = highest); registered.

Behaviour:
- Registers (bits ≥ CH read 0, writes ignored):
  - addr 0, mask: read/write.
  - addr 1, mode: read/write.
  - addr 2, pending: read returns the pending bits; writing 1 clears the bit, writing 0 has no effect.
  - addr 3, overflow: read returns the overflow bits; writing 1 clears the bit.
- Reset (asynchronous, rstn=0):
  - mask=MASK0, mode=MODE0, pending=0, overflow=0.
  - Previous-sample register = all ones.
  - irq_n=1, vec=0.
  - A reset mid-pending discards all state; no interrupt is emitted after release until a new trigger arrives.
- Sampling:
  - src_n is sampled every clk into the previous-sample register, regardless of dip_pause.
  - Consequently, a line already low when pause ends is not treated as an edge.
- Edge channel:
  - Falling edge (prev=1, cur=0) with dip_pause=1 sets pending.
  - If pending is already 1 at that edge, the overflow bit is set; the pending bit stays 1.
- Level channel:
  - pending is registered each clk as ~src_n & dip_pause.
  - Ack and register clears have no lasting effect while the source is still low.
  - Overflow is never set in level mode.
- Ack:
  - On irq_ack, the pending bit of channel vec is cleared, provided that channel is in edge mode and unmasked-pending.
  - If nothing is unmasked-pending, ack is ignored.
- Simultaneous events on the same channel in one cycle:
  - A set (new edge) wins over an ack clear or a register clear.
  - Overflow is not raised in that case, because the old event was consumed.
- Masked channels keep latching pending and overflow but do not drive irq_n or vec.
- Outputs:
  - irq_n is registered: irq_n <= ~|(pending & mask).
  - Latency: src_n falls at cycle t → pending=1 at t+1 → irq_n=0 at t+2.
  - vec is registered in the same cycle as irq_n, using lowest-index-first priority; it holds its last value when nothing is pending.
- Mode change:
  - Edge→level: pending follows the level from the next cycle.
  - Level→edge: the current pending value is kept; only new falling edges set it further.
- dip_pause=0: existing edge pending bits persist and still assert irq_n; level channels drop pending.

Test Plan:
- Reset, then pulse src_n[1] low for 1 cycle → pending=0x02 at t+1, irq_n=0 at t+2, vec=1; irq_ack pulse → pending=0x00, irq_n=1 one cycle later.
- Edges on ch0 and ch2 in the same cycle → vec=0; ack → vec=2, irq_n stays 0; second ack → irq_n=1.
- Two falling edges on ch3 without ack → dout@addr3=0x08; write 0x08 to addr3 → 0x00; pending@addr2 still 0x08.
- Write mask=0x0E, then edge on ch0 → addr2 reads 0x01, irq_n stays 1; write mask=0x0F → irq_n=0 two cycles later.
- Mode=0x00 (all level), hold src_n[2] low, irq_ack → pending bit 2 stays 1; release src_n → irq_n=1 at t+2.
- dip_pause=0, drive src_n[0] low, raise dip_pause with src_n still low → no pending; ack on the same cycle as a new edge on ch1 → pending[1]=1, overflow[1]=0.

Source files
------------

// File: rtl/jtcontra_irq_ctrl.sv
// jtcontra_irq_ctrl: CH-channel edge/level interrupt controller with mask, pending, overflow and priority vector
module jtcontra_irq_ctrl #(
  parameter int         CH    = 4,
  parameter logic [7:0] MASK0 = 8'hFF,
  parameter logic [7:0] MODE0 = 8'hFF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          dip_pause,
  input  logic [CH-1:0] src_n,
  input  logic          irq_ack,
  input  logic          wr,
  input  logic [1:0]    addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          irq_n,
  output logic [2:0]    vec
);
  logic [CH-1:0] mask, mode, pend, ovf, prev;
  logic [CH-1:0] fall, unm, ack_oh, clr, ovf_clr, pend_nx, ovf_nx, rd;
  logic [2:0]    vec_nx;
  always_comb begin
    fall    = prev & ~src_n & {CH{dip_pause}};
    unm     = pend & mask;
    vec_nx  = vec;
    for (int i = CH - 1; i >= 0; i--) if (unm[i]) vec_nx = 3'(i);
    for (int i = 0; i < CH; i++) ack_oh[i] = irq_ack && vec == 3'(i) && unm[i] && mode[i];
    clr     = ack_oh | ((wr && addr == 2'd2) ? din[CH-1:0] : '0);
    ovf_clr = (wr && addr == 2'd3) ? din[CH-1:0] : '0;
    // a new edge beats any clear in the same cycle, and then the old event counts as consumed
    pend_nx = (mode & (fall | (pend & ~clr))) | (~mode & ~src_n & {CH{dip_pause}});
    ovf_nx  = (ovf & ~ovf_clr) | (mode & fall & pend & ~clr);
  end
  always_comb begin
    rd   = addr == 2'd0 ? mask : addr == 2'd1 ? mode : addr == 2'd2 ? pend : ovf;
    dout = '0;
    dout[CH-1:0] = rd;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask  <= MASK0[CH-1:0];
      mode  <= MODE0[CH-1:0];
      pend  <= '0;
      ovf   <= '0;
      prev  <= '1;
      irq_n <= 1'b1;
      vec   <= '0;
    end else begin
      prev  <= src_n;
      pend  <= pend_nx;
      ovf   <= ovf_nx;
      irq_n <= ~|unm;
      vec   <= vec_nx;
      if (wr && addr == 2'd0) mask <= din[CH-1:0];
      if (wr && addr == 2'd1) mode <= din[CH-1:0];
    end
  end
endmodule

// File: tb/tb_jtcontra_irq_ctrl.sv
// tb_jtcontra_irq_ctrl: directed scenarios plus randomized traffic checked against a per-channel behavioural model
module tb_jtcontra_irq_ctrl;
  localparam int         CH    = 4;
  localparam logic [7:0] MASK0 = 8'hFF;
  localparam logic [7:0] MODE0 = 8'hFF;
  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          dip_pause = 1'b1;
  logic [CH-1:0] src_n = '1;
  logic          irq_ack = 1'b0;
  logic          wr = 1'b0;
  logic [1:0]    addr = '0;
  logic [7:0]    din = '0;
  logic [7:0]    dout;
  logic          irq_n;
  logic [2:0]    vec;
  int n_cmp = 0;
  int n_err = 0;
  jtcontra_irq_ctrl #(.CH(CH), .MASK0(MASK0), .MODE0(MODE0)) dut (
    .clk(clk), .rstn(rstn), .dip_pause(dip_pause), .src_n(src_n), .irq_ack(irq_ack),
    .wr(wr), .addr(addr), .din(din), .dout(dout), .irq_n(irq_n), .vec(vec)
  );
  always #5 clk = ~clk;
  logic [CH-1:0] m_mask, m_mode, m_pend, m_ovf, m_prev;
  logic          m_irq_n;
  int            m_vec;
  function automatic bit fell(int i);
    return m_prev[i] && !src_n[i] && dip_pause;
  endfunction
  function automatic bit ack_hit(int i);
    return irq_ack && m_vec == i && m_pend[i] && m_mask[i] && m_mode[i];
  endfunction
  function automatic bit wclr(int i);
    return ack_hit(i) || (wr && addr == 2 && din[i]);
  endfunction
  function automatic bit nxt_pend(int i);
    if (!m_mode[i]) return !src_n[i] && dip_pause;
    if (fell(i)) return 1'b1;
    return m_pend[i] && !wclr(i);
  endfunction
  function automatic bit nxt_ovf(int i);
    bit cl = wr && addr == 3 && din[i];
    bit st = m_mode[i] && fell(i) && m_pend[i] && !wclr(i);
    return (m_ovf[i] && !cl) || st;
  endfunction
  function automatic int first_unm();
    for (int i = 0; i < CH; i++) if (m_pend[i] && m_mask[i]) return i;
    return m_vec;
  endfunction
  function automatic logic [7:0] exp_dout();
    logic [CH-1:0] r = addr == 0 ? m_mask : addr == 1 ? m_mode : addr == 2 ? m_pend : m_ovf;
    return 8'(r);
  endfunction
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mask  <= MASK0[CH-1:0];
      m_mode  <= MODE0[CH-1:0];
      m_pend  <= '0;
      m_ovf   <= '0;
      m_prev  <= '1;
      m_irq_n <= 1'b1;
      m_vec   <= 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        m_pend[i] <= nxt_pend(i);
        m_ovf[i]  <= nxt_ovf(i);
      end
      m_prev  <= src_n;
      m_irq_n <= (m_pend & m_mask) == '0;
      m_vec   <= first_unm();
      if (wr && addr == 0) m_mask <= din[CH-1:0];
      if (wr && addr == 1) m_mode <= din[CH-1:0];
    end
  end
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("model irq_n", 8'(irq_n), 8'(m_irq_n));
    chk("model vec", 8'(vec), 8'(m_vec));
    chk("model dout", dout, exp_dout());
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wreg(input logic [1:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    tick();
    wr = 1'b0;
  endtask
  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask
  initial begin
    #1 rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    chk("reset irq_n", 8'(irq_n), 8'h01);
    chk("reset vec", 8'(vec), 8'h00);
    addr = 0; #1 chk("reset mask", dout, 8'h0F);
    addr = 1; #1 chk("reset mode", dout, 8'h0F);
    addr = 2; #1 chk("reset pend", dout, 8'h00);
    // single edge on ch1, then ack
    src_n = 4'b1101; tick();
    src_n = 4'b1111;
    chk("t1 pend", dout, 8'h02);
    chk("t1 irq_n t+1", 8'(irq_n), 8'h01);
    tick();
    chk("t1 irq_n t+2", 8'(irq_n), 8'h00);
    chk("t1 vec", 8'(vec), 8'h01);
    ack();
    chk("t1 pend after ack", dout, 8'h00);
    tick();
    chk("t1 irq_n release", 8'(irq_n), 8'h01);
    // simultaneous edges on ch0 and ch2
    src_n = 4'b1010; tick();
    src_n = 4'b1111; tick();
    chk("t2 vec0", 8'(vec), 8'h00);
    chk("t2 irq_n", 8'(irq_n), 8'h00);
    ack(); tick();
    chk("t2 vec2", 8'(vec), 8'h02);
    chk("t2 irq_n held", 8'(irq_n), 8'h00);
    ack(); tick();
    chk("t2 irq_n release", 8'(irq_n), 8'h01);
    // double edge on ch3 raises overflow
    src_n = 4'b0111; tick();
    src_n = 4'b1111; tick();
    src_n = 4'b0111; tick();
    src_n = 4'b1111; tick();
    addr = 3; #1 chk("t3 ovf", dout, 8'h08);
    wreg(3, 8'h08);
    addr = 3; #1 chk("t3 ovf cleared", dout, 8'h00);
    addr = 2; #1 chk("t3 pend kept", dout, 8'h08);
    wreg(2, 8'h08); tick(); tick();
    chk("t3 irq_n release", 8'(irq_n), 8'h01);
    // masked channel latches without interrupting
    wreg(0, 8'h0E);
    src_n = 4'b1110; tick();
    src_n = 4'b1111; addr = 2;
    #1 chk("t4 masked pend", dout, 8'h01);
    tick(); tick();
    chk("t4 masked irq_n", 8'(irq_n), 8'h01);
    wreg(0, 8'h0F);
    chk("t4 unmask t+1", 8'(irq_n), 8'h01);
    tick();
    chk("t4 unmask t+2", 8'(irq_n), 8'h00);
    ack(); tick(); tick();
    // level mode ignores ack while source is low
    wreg(1, 8'h00);
    src_n = 4'b1011; tick(); tick();
    chk("t5 irq_n", 8'(irq_n), 8'h00);
    chk("t5 vec", 8'(vec), 8'h02);
    ack(); addr = 2;
    #1 chk("t5 pend after ack", dout, 8'h04);
    src_n = 4'b1111; tick();
    chk("t5 pend released", dout, 8'h00);
    chk("t5 irq_n t+1", 8'(irq_n), 8'h00);
    tick();
    chk("t5 irq_n t+2", 8'(irq_n), 8'h01);
    wreg(1, 8'h0F); tick();
    // line already low when pause ends is not an edge
    dip_pause = 1'b0; src_n = 4'b1110; tick(); tick();
    dip_pause = 1'b1; tick(); tick(); addr = 2;
    #1 chk("t6 no pend", dout, 8'h00);
    chk("t6 irq_n", 8'(irq_n), 8'h01);
    src_n = 4'b1111; tick();
    src_n = 4'b1101; tick();
    src_n = 4'b1111; tick(); tick();
    chk("t6 vec1", 8'(vec), 8'h01);
    src_n = 4'b1101; irq_ack = 1'b1; tick();
    irq_ack = 1'b0; src_n = 4'b1111; addr = 2;
    #1 chk("t6 edge beats ack", dout, 8'h02);
    addr = 3; #1 chk("t6 no ovf", dout, 8'h00);
    ack(); tick(); tick();
    // randomized traffic with occasional mid-run resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < CH; i++) if ($urandom_range(2) == 0) src_n[i] = ~src_n[i];
      dip_pause = $urandom_range(15) != 0;
      irq_ack   = $urandom_range(3) == 0;
      wr        = $urandom_range(7) == 0;
      addr      = 2'($urandom_range(3));
      din       = 8'($urandom);
      if ($urandom_range(499) == 0) begin
        rstn = 1'b0; tick(); tick(); rstn = 1'b1;
      end
      tick();
    end
    wr = 1'b0; irq_ack = 1'b0;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
